// File: rtl/pc_exc_pkg.sv
// Shared types for the PC / exception unit: cause and branch encodings,
// sequencer states, default vector base and the vector address helper.
package pc_exc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [7:0] VEC_BASE_DFLT = 8'd252;

  typedef enum logic [1:0] {
    CAUSE_RSVD   = 2'b00,
    CAUSE_INV_OP = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LE = 2'b10,
    BR_GT = 2'b11
  } branch_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_LOAD = 2'b10
  } exc_state_e;

  // Byte address of the vector entry for a cause, zero-extended to XLEN.
  function automatic logic [XLEN-1:0] vec_addr(input logic [7:0] base,
                                               input logic [1:0] cause);
    return {{(XLEN-8){1'b0}}, 8'(base + {6'b0, cause})};
  endfunction

endpackage

// File: rtl/pc_branch_cond.sv
// Combinational branch-condition decoder: maps branch type and ALU flags
// to a take/not-take decision.
module pc_branch_cond
  import pc_exc_pkg::*;
(
  input  logic [1:0] branch_type_i,
  input  logic       alu_zero_i,
  input  logic       alu_gt_i,
  output logic       take_branch_c_o
);

  always_comb begin
    take_branch_c_o = 1'b0;
    case (branch_type_e'(branch_type_i))
      BR_EQ:   take_branch_c_o = alu_zero_i;
      BR_NE:   take_branch_c_o = !alu_zero_i;
      BR_LE:   take_branch_c_o = alu_zero_i | !alu_gt_i;
      BR_GT:   take_branch_c_o = alu_gt_i;
      default: take_branch_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_exception_unit.sv
// Program counter, EPC and exception-entry sequencer (IDLE -> RD -> LOAD).
// Optional build macro PC_ALIGN_CHECK_EN turns misaligned PC commits into cause-00 exceptions.
module pc_exception_unit
  import pc_exc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     MEM_LAT  = 1,
  parameter logic [7:0]      VEC_BASE = VEC_BASE_DFLT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_write,
  input  logic            pc_write_cond,
  input  logic [1:0]      branch_type,
  input  logic            alu_zero,
  input  logic            alu_gt,
  input  logic [XLEN-1:0] pc_next,
  input  logic            exc_req,
  input  logic [1:0]      exc_cause,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] epc_out,
  output logic            exc_mem_rd,
  output logic [XLEN-1:0] exc_mem_addr,
  output logic            exc_busy,
  output logic            exc_done
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             take_branch_c;
  logic             commit_req_c;
  logic             exc_start_c;
  logic [1:0]       start_cause_c;

  // Only the low byte lane carries the handler address.
  logic             unused_rdata;
  assign unused_rdata = ^mem_rdata[XLEN-1:8];

  pc_branch_cond u_branch_cond (
    .branch_type_i   (branch_type),
    .alu_zero_i      (alu_zero),
    .alu_gt_i        (alu_gt),
    .take_branch_c_o (take_branch_c)
  );

  assign commit_req_c = pc_write | (pc_write_cond & take_branch_c);

  // Exception admission; requests are only seen in IDLE, so a busy sequence keeps its cause.
`ifdef PC_ALIGN_CHECK_EN
  logic misalign_c;
  assign misalign_c    = commit_req_c & (pc_next[1:0] != 2'b00);
  assign exc_start_c   = (state_q == ST_IDLE) & (exc_req | misalign_c);
  assign start_cause_c = exc_req ? exc_cause : 2'(CAUSE_RSVD);
`else
  assign exc_start_c   = (state_q == ST_IDLE) & exc_req & (exc_cause != 2'(CAUSE_RSVD));
  assign start_cause_c = exc_cause;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; RD holds for MEM_LAT cycles so LOAD sees valid read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (exc_start_c) state_d = ST_RD;
      end
      ST_RD: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; an accepted exception discards any PC commit.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    addr_d   = addr_q;
    mem_rd_d = (state_d == ST_RD);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_LOAD);
    if (state_q == ST_LOAD) begin
      pc_d = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
    end else if (exc_start_c) begin
      epc_d  = pc_q - XLEN'(4);
      addr_d = vec_addr(VEC_BASE, start_cause_c);
    end else if ((state_q == ST_IDLE) && commit_req_c) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      epc_q    <= '0;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      addr_q   <= addr_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pc_out       = pc_q;
  assign epc_out      = epc_q;
  assign exc_mem_addr = addr_q;
  assign exc_mem_rd   = mem_rd_q;
  assign exc_busy     = busy_q;
  assign exc_done     = done_q;

endmodule

// File: tb/tb_pc_exception_unit.sv
// Self-checking bench for pc_exception_unit: directed steps followed by random
// traffic, compared every cycle against a cycle-count reference model.
module tb_pc_exception_unit;

  localparam int unsigned MEM_LAT  = 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [7:0]  VEC_BASE = 8'd252;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pc_write, pc_write_cond, alu_zero, alu_gt, exc_req;
  logic [1:0]  branch_type, exc_cause;
  logic [31:0] pc_next, mem_rdata;
  logic [31:0] pc_out, epc_out, exc_mem_addr;
  logic        exc_mem_rd, exc_busy, exc_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural registers plus cycles elapsed since exception entry.
  logic [31:0] m_pc, m_epc, m_addr;
  int          m_seq;
  bit          m_done;

  pc_exception_unit #(
    .RESET_PC (RESET_PC),
    .MEM_LAT  (MEM_LAT),
    .VEC_BASE (VEC_BASE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_type   (branch_type),
    .alu_zero      (alu_zero),
    .alu_gt        (alu_gt),
    .pc_next       (pc_next),
    .exc_req       (exc_req),
    .exc_cause     (exc_cause),
    .mem_rdata     (mem_rdata),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .exc_mem_rd    (exc_mem_rd),
    .exc_mem_addr  (exc_mem_addr),
    .exc_busy      (exc_busy),
    .exc_done      (exc_done)
  );

  always #5 clk = ~clk;

  function automatic bit branch_taken(input logic [1:0] bt, input logic z, input logic gt);
    case (bt)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return z || !gt;
      default: return gt;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("epc_out", epc_out, m_epc);
    chk("exc_mem_addr", exc_mem_addr, m_addr);
    chk("exc_mem_rd", 32'(exc_mem_rd), 32'(m_seq >= 1 && m_seq <= int'(MEM_LAT)));
    chk("exc_busy", 32'(exc_busy), 32'(m_seq != 0));
    chk("exc_done", 32'(exc_done), 32'(m_done));
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit         take, accept;
    logic [1:0] c;
    m_done = 1'b0;
    if (m_seq != 0) begin
      if (m_seq == int'(MEM_LAT) + 1) begin
        m_pc   = {24'h0, mem_rdata[7:0]};
        m_seq  = 0;
        m_done = 1'b1;
      end else begin
        m_seq++;
      end
    end else begin
      take   = pc_write || (pc_write_cond && branch_taken(branch_type, alu_zero, alu_gt));
      accept = exc_req && (exc_cause != 2'b00 || ALIGN);
      c      = exc_cause;
      if (!accept && ALIGN && take && pc_next[1:0] != 2'b00) begin
        accept = 1'b1;
        c      = 2'b00;
      end
      if (accept) begin
        m_epc  = m_pc - 32'd4;
        m_addr = {24'h0, 8'(VEC_BASE + {6'b0, c})};
        m_seq  = 1;
      end else if (take) begin
        m_pc = pc_next;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    pc_write = 1'b0; pc_write_cond = 1'b0; branch_type = 2'b00;
    alu_zero = 1'b0; alu_gt = 1'b0; pc_next = 32'h0;
    exc_req = 1'b0; exc_cause = 2'b00;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    m_pc = RESET_PC; m_epc = 32'h0; m_addr = 32'h0; m_seq = 0; m_done = 1'b0;
    check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    mem_rdata = 32'h0;
    #2 apply_reset();
    chk("reset_pc", pc_out, 32'h0);

    pc_write = 1'b1; pc_next = 32'h4; step();
    chk("pc_write_4", pc_out, 32'h4);
    idle_inputs();

    pc_write_cond = 1'b1; branch_type = 2'b00; alu_zero = 1'b1; pc_next = 32'h40; step();
    chk("beq_taken", pc_out, 32'h40);
    branch_type = 2'b01; alu_zero = 1'b1; pc_next = 32'h80; step();
    chk("bne_not_taken", pc_out, 32'h40);
    branch_type = 2'b11; alu_zero = 1'b0; alu_gt = 1'b1; pc_next = 32'h60; step();
    chk("bgt_taken", pc_out, 32'h60);
    branch_type = 2'b10; alu_zero = 1'b0; alu_gt = 1'b1; pc_next = 32'h90; step();
    chk("ble_not_taken", pc_out, 32'h60);
    idle_inputs();

    // Overflow exception from PC 0x100, handler byte 0x80.
    pc_write = 1'b1; pc_next = 32'h100; step();
    idle_inputs();
    exc_req = 1'b1; exc_cause = 2'b10; mem_rdata = 32'h1234_5680; step();
    chk("ovf_epc", epc_out, 32'hFC);
    chk("ovf_addr", exc_mem_addr, 32'd254);
    chk("ovf_rd_on", 32'(exc_mem_rd), 32'd1);
    exc_req = 1'b0; step();
    chk("ovf_rd_off", 32'(exc_mem_rd), 32'd0);
    step();
    chk("ovf_handler", pc_out, 32'h80);
    chk("ovf_done", 32'(exc_done), 32'd1);
    step();

    // Exception beats a simultaneous pc_write; a second request while busy is dropped.
    pc_write = 1'b1; pc_next = 32'h200; exc_req = 1'b1; exc_cause = 2'b01;
    mem_rdata = 32'hFFFF_FF24; step();
    chk("simul_addr", exc_mem_addr, 32'd253);
    exc_cause = 2'b11; step();
    chk("busy_addr_held", exc_mem_addr, 32'd253);
    idle_inputs(); step();
    chk("simul_handler", pc_out, 32'h24);
    chk("simul_epc", epc_out, 32'h7C);
    step();

    // Reset while the read is in flight.
    exc_req = 1'b1; exc_cause = 2'b11; step();
    exc_req = 1'b0;
    #2 apply_reset();
    chk("rst_epc_cleared", epc_out, 32'h0);
    pc_write = 1'b1; pc_next = 32'h10; step();
    chk("post_rst_write", pc_out, 32'h10);

    // Misaligned commit.
    pc_next = 32'h202; step();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_no_commit", pc_out, 32'h10);
    chk("align_addr", exc_mem_addr, 32'd252);
    chk("align_busy", 32'(exc_busy), 32'd1);
`else
    chk("misaligned_load", pc_out, 32'h202);
`endif
    idle_inputs();
    repeat (MEM_LAT + 2) step();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      branch_type   = 2'($urandom);
      alu_zero      = 1'($urandom);
      alu_gt        = 1'($urandom);
      pc_next       = $urandom;
      if ($urandom_range(0, 9) != 0) pc_next[1:0] = 2'b00;
      exc_req       = ($urandom_range(0, 7) == 0);
      exc_cause     = 2'($urandom);
      mem_rdata     = $urandom;
      step();
      if ($urandom_range(0, 199) == 0) begin
        #2 apply_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_exception_unit.md
Name: pc_exception_unit

Overview:
- Owns the program counter register and the EPC register, and sequences exception entry.
- Consumes the selected next-PC from the PC-source multiplexer and commits it under unconditional-write or branch-condition control.
- Supplies epc_out back to that multiplexer.
- On an exception: saves the faulting PC in EPC, reads the handler address byte from the memory vector table, and loads it into PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- MEM_LAT, 1, memory read latency in cycles (1..7) between exc_mem_rd assertion and valid mem_rdata.
- VEC_BASE, 8'd252, byte address of vector entry 0; the entry for cause c is at VEC_BASE + c.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  unconditional PC write.
- pc_write_cond  in  1  conditional PC write (branch).
- branch_type  in  2  00 beq, 01 bne, 10 ble, 11 bgt.
- alu_zero  in  1  ALU result zero flag.
- alu_gt  in  1  ALU A>B flag (signed).
- pc_next  in  32  output of the PC-source mux.
- exc_req  in  1  exception request from control, 1-cycle pulse.
- exc_cause  in  2  01 invalid opcode, 10 overflow, 11 divide-by-zero, 00 reserved.
- mem_rdata  in  32  memory read data; byte lane [7:0] holds the vector.
- pc_out  out  32  current PC.
- epc_out  out  32  exception PC.
- exc_mem_rd  out  1  memory read request, owned by this block while busy.
- exc_mem_addr  out  32  vector address {24'b0, VEC_BASE+cause}.
- exc_busy  out  1  sequencer active; control must stall.
- exc_done  out  1  1-cycle pulse when the handler address is loaded.

Behaviour:
- Reset (async, reset_n=0):
  - pc_out=RESET_PC, epc_out=0.
  - exc_mem_rd=0, exc_mem_addr=0, exc_busy=0, exc_done=0.
  - FSM=IDLE, latency counter=0.
  - Reset asserted mid-sequence aborts the sequence immediately. EPC written in that sequence is also cleared.
- Branch condition:
  - beq: alu_zero.
  - bne: !alu_zero.
  - ble: alu_zero | !alu_gt.
  - bgt: alu_gt.
- PC commit in IDLE, at the clock edge:
  - PC <= pc_next if pc_write, or if (pc_write_cond and condition true).
  - Zero added latency: pc_out reflects the new value the cycle after the edge.
- FSM:
  - IDLE: on exc_req with a valid cause:
    - Latch cause.
    - EPC <= pc_out - 4 (32-bit wrap; PC=0 gives EPC=32'hFFFF_FFFC).
    - Set exc_busy=1.
    - Go to RD.
  - RD:
    - exc_mem_rd=1, exc_mem_addr valid.
    - Counter counts MEM_LAT cycles, then go to LOAD.
  - LOAD:
    - PC <= {24'b0, mem_rdata[7:0]}.
    - exc_done=1 for this cycle.
    - Go to IDLE. exc_busy deasserts in the cycle after LOAD.
- Total exception latency is 2+MEM_LAT cycles from exc_req to exc_done.
- Simultaneous events:
  - exc_req together with pc_write or pc_write_cond: exception wins, pc_next is discarded.
  - exc_req, pc_write and pc_write_cond are all ignored while exc_busy=1. The cause latched first is kept.
  - exc_cause=00 without the optional feature is ignored: no state change.
- epc_out changes only on exception entry and reset.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: a PC commit whose pc_next[1:0]!=0 is suppressed.
  - Internal exception with cause 00 starts instead: vector VEC_BASE+0.
  - EPC <= pc_out - 4, i.e. the PC of the branching instruction's successor minus 4.
  - External exc_req with cause 00 is also accepted.
- Undefined: no alignment check. Misaligned values load as-is, and cause 00 is ignored.

Decomposition:
- Shared package pc_exc_pkg:
  - Cause encodings.
  - Branch-type encodings.
  - FSM state enum (IDLE, RD, LOAD).
  - Default VEC_BASE.
- One natural sub-module: pc_branch_cond, a combinational condition decoder taking branch_type and the flags and producing take_branch.

Test Plan:
- Reset release → pc_out=0, epc_out=0; then pc_write=1, pc_next=32'h0000_0004 → pc_out=4 next cycle.
- pc_write_cond=1 with:
  - branch_type=00, alu_zero=1, pc_next=32'h40 → PC=0x40.
  - branch_type=01, alu_zero=1 → PC unchanged.
  - branch_type=11, alu_gt=1 → taken.
  - branch_type=10, alu_gt=1, alu_zero=0 → not taken.
- PC=0x100, exc_req with cause 10 (overflow), MEM_LAT=1, mem_rdata[7:0]=0x80:
  - epc_out=0xFC.
  - exc_mem_addr=254, exc_mem_rd high one cycle.
  - PC=0x80 with exc_done after 3 cycles.
- exc_req and pc_write=1 (pc_next=0x200) in the same cycle → exception taken, PC never 0x200. A second exc_req while busy is ignored; the first cause's vector address is held.
- reset_n low during RD → all outputs at reset values asynchronously; after release, a normal pc_write works.
- With PC_ALIGN_CHECK_EN defined, pc_write with pc_next=0x202 → no commit, exc_mem_addr=252, exc_busy=1. Without the macro, PC=0x202.
